// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow strobe derived from clk_i and flags lock/timeout.
// Define CLOCK_PERIOD_METER_SYNC_EN to add a two-flop synchronizer ahead of edge detection.
module clock_period_meter #(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     sig_i,
  output logic [COUNTER_WIDTH-1:0] period_o,
  output logic [COUNTER_WIDTH-1:0] high_o,
  output logic                     valid_o,
  output logic                     lock_o,
  output logic                     timeout_o
);

  typedef enum logic {IDLE, MEAS} state_e;

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] hcap_q, hcap_d;
  logic [COUNTER_WIDTH-1:0] period_q, period_d;
  logic [COUNTER_WIDTH-1:0] high_q, high_d;
  logic                     valid_q, valid_d;
  logic                     lock_q, lock_d;
  logic                     timeout_q, timeout_d;
  logic                     have_q, have_d;
  logic                     sig_q, prev_q;
  logic                     rise, fall;

`ifdef CLOCK_PERIOD_METER_SYNC_EN
  logic sig_m_q;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      sig_m_q <= 1'b0;
      sig_q   <= 1'b0;
    end else begin
      sig_m_q <= sig_i;
      sig_q   <= sig_m_q;
    end
  end
`else
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_i;
  end
`endif

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= sig_q;
  end

  assign rise = sig_q & ~prev_q;
  assign fall = ~sig_q & prev_q;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcap_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      lock_q    <= 1'b0;
      timeout_q <= 1'b0;
      have_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcap_q    <= hcap_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      lock_q    <= lock_d;
      timeout_q <= timeout_d;
      have_q    <= have_d;
    end
  end

  // A rise closing a period beats the saturation timeout; dropping en_i beats both.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcap_d    = hcap_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    lock_d    = lock_q;
    timeout_d = 1'b0;
    have_d    = have_q;
    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      lock_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise) begin
            state_d = MEAS;
            cnt_d   = CNT_ONE;
            have_d  = 1'b0;
          end
        end
        MEAS: begin
          if (fall) hcap_d = cnt_q;
          if (rise) begin
            period_d = cnt_q;
            high_d   = hcap_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
            lock_d   = have_q && (cnt_q == period_q) && (hcap_q == high_q);
            have_d   = 1'b1;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            lock_d    = 1'b0;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign valid_o   = valid_q;
  assign lock_o    = lock_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomized scoreboard bench for clock_period_meter (COUNTER_WIDTH=4): edge-time reference model
// pushes expected measurements/timeouts; a negedge monitor pops them when the DUT reports.
module tb_clock_period_meter;

  localparam int CW   = 4;
  localparam int MAXP = (1 << CW) - 1;
`ifdef CLOCK_PERIOD_METER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk_i = 1'b0;
  logic          rst   = 1'b1;
  logic          en_i  = 1'b0;
  logic          sig_i = 1'b0;
  logic [CW-1:0] period_o;
  logic [CW-1:0] high_o;
  logic          valid_o;
  logic          lock_o;
  logic          timeout_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit isTimeout;
    int p;
    int h;
    bit lock;
    int due;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  // Reference model state, expressed in sig_i edge times
  bit mLevel  = 1'b0;
  bit mActive = 1'b0;
  bit mHave   = 1'b0;
  int mLastRise = 0;
  int mHigh  = 0;
  int mPrevP = 0;
  int mPrevH = 0;

  clock_period_meter #(.COUNTER_WIDTH(CW)) dut (
    .clk_i    (clk_i),
    .rst      (rst),
    .en_i     (en_i),
    .sig_i    (sig_i),
    .period_o (period_o),
    .high_o   (high_o),
    .valid_o  (valid_o),
    .lock_o   (lock_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushExp(input bit isTo, input int p, input int h, input bit lk);
    exp_t e;
    e.isTimeout = isTo;
    e.p         = p;
    e.h         = h;
    e.lock      = lk;
    e.due       = cyc + LAT;
    expQ.push_back(e);
  endtask

  // One clk_i cycle of stimulus plus the model's view of that cycle
  task automatic stepCycle(input logic lvl, input logic en);
    bit rise;
    bit fall;
    int p;
    @(posedge clk_i);
    #1;
    sig_i = lvl;
    en_i  = en;
    rise  = lvl && !mLevel;
    fall  = !lvl && mLevel;
    mLevel = lvl;
    if (!en) begin
      mActive = 1'b0;
    end else if (rise) begin
      if (mActive) begin
        p = cyc - mLastRise;
        pushExp(1'b0, p, mHigh, mHave && (p == mPrevP) && (mHigh == mPrevH));
        mPrevP = p;
        mPrevH = mHigh;
        mHave  = 1'b1;
      end else begin
        mActive = 1'b1;
        mHave   = 1'b0;
      end
      mLastRise = cyc;
    end else if (mActive) begin
      if (fall) mHigh = cyc - mLastRise;
      if (cyc - mLastRise == MAXP) begin
        pushExp(1'b1, mPrevP, mPrevH, 1'b0);
        mActive = 1'b0;
      end
    end
  endtask

  // One high phase then one low phase; dropAt >= 0 pulls en_i low for that low-phase cycle
  task automatic applyStimulus(input int hi, input int lo, input int dropAt);
    for (int i = 0; i < hi; i++) stepCycle(1'b1, 1'b1);
    for (int i = 0; i < lo; i++) begin
      stepCycle(1'b0, (i == dropAt) ? 1'b0 : 1'b1);
      if (dropAt >= 0 && i == dropAt + 1) begin
        checkOutput("lock_after_en_drop", {31'd0, lock_o}, 32'd0);
        checkOutput("period_hold_after_en_drop", {28'd0, period_o}, mPrevP);
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_period"},  {28'd0, period_o}, 32'd0);
    checkOutput({tag, "_high"},    {28'd0, high_o},   32'd0);
    checkOutput({tag, "_valid"},   {31'd0, valid_o},  32'd0);
    checkOutput({tag, "_lock"},    {31'd0, lock_o},   32'd0);
    checkOutput({tag, "_timeout"}, {31'd0, timeout_o}, 32'd0);
  endtask

  task automatic doReset();
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    checkOutput("pending_at_reset", expQ.size(), 32'd0);
    sig_i   = 1'b0;
    mLevel  = 1'b0;
    mActive = 1'b0;
    mHave   = 1'b0;
    mHigh   = 0;
    mPrevP  = 0;
    mPrevH  = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every reported output must match the oldest expectation, including its timing
  always @(negedge clk_i) begin
    if (!rst && (valid_o || timeout_o)) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_output: got valid=%0b timeout=%0b period=%0d, expected no output (cycle %0d)",
                 valid_o, timeout_o, period_o, cyc);
      end else begin
        monE = expQ.pop_front();
        checkOutput("timeout_flag", {31'd0, timeout_o}, {31'd0, monE.isTimeout});
        checkOutput("valid_flag",   {31'd0, valid_o},   {31'd0, !monE.isTimeout});
        checkOutput("period",       {28'd0, period_o},  monE.p);
        checkOutput("high",         {28'd0, high_o},    monE.h);
        checkOutput("lock",         {31'd0, lock_o},    {31'd0, monE.lock});
        checkOutput("latency",      cyc,                monE.due);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hi, lo, r, lastHi, lastLo, drop;
    rst = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    repeat (3) stepCycle(1'b0, 1'b1);

    $display("[TB] square wave toggling every 4");
    repeat (6) applyStimulus(4, 4, -1);

    $display("[TB] duty change 3/5 then 5/3");
    repeat (4) applyStimulus(3, 5, -1);
    repeat (4) applyStimulus(5, 3, -1);

    $display("[TB] timeout then period exactly at saturation");
    applyStimulus(3, 20, -1);
    repeat (4) applyStimulus(7, MAXP - 7, -1);

    $display("[TB] en_i dropped mid-period");
    repeat (3) applyStimulus(6, 6, -1);
    applyStimulus(6, 6, 3);
    repeat (3) applyStimulus(6, 6, -1);

    $display("[TB] randomized periods");
    lastHi = 4;
    lastLo = 4;
    for (int k = 0; k < 60; k++) begin
      r    = $urandom_range(0, 9);
      hi   = $urandom_range(2, 7);
      drop = -1;
      if (r == 0) lo = MAXP - hi;
      else if (r == 1) lo = $urandom_range(16, 20);
      else if (r < 6) begin
        hi = lastHi;
        lo = lastLo;
      end else begin
        lo = $urandom_range(2, 7);
        if (r == 9 && lo >= 5) drop = 2;
      end
      applyStimulus(hi, lo, drop);
      lastHi = hi;
      lastLo = lo;
    end

    $display("[TB] async reset while locked");
    repeat (4) applyStimulus(4, 4, -1);
    repeat (3) stepCycle(1'b0, 1'b1);
    checkOutput("lock_before_reset", {31'd0, lock_o}, 32'd1);
    doReset();
    repeat (4) applyStimulus(4, 4, -1);

    repeat (20) stepCycle(1'b0, 1'b1);
    repeat (LAT + 2) stepCycle(1'b0, 1'b0);
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
